// File: rtl/audio_level_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_level_meter_if
// Purpose  : Sample input / LED output bundle of the audio level meter.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_level_meter_if #(
  parameter int NCH  = 2,
  parameter int DW   = 16,
  parameter int SEGS = 4
);
  logic                 smp_vld;
  logic [NCH*DW-1:0]    smp;
  logic                 mode;
  logic                 clip_clr;
  logic [NCH*SEGS-1:0]  LED;
  logic [NCH-1:0]       clip;

  modport master (output smp_vld, smp, mode, clip_clr, input LED, clip);
  modport slave  (input smp_vld, smp, mode, clip_clr, output LED, clip);
endinterface
`default_nettype wire

// File: rtl/audio_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : audio_level_meter
// Purpose  : Multi-channel LED VU meter with fall-off, peak-hold dot and clip.
// Revision : 1.0 - initial release
// ============================================================================
module audio_level_meter #(
  parameter int             NCH        = 2,
  parameter int             DW         = 16,
  parameter int             SEGS       = 4,
  parameter int             SHIFT      = 2,
  parameter int             TICK_DIV   = 2**26,
  parameter int             HOLD_TICKS = 8,
  parameter logic [NCH-1:0] MIRROR     = NCH'(1)
) (
  input  logic              clk,
  input  logic              rst,
  audio_level_meter_if.slave bus
);
  localparam int AW = DW - 1;
  localparam int NW = $clog2(SEGS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] c_smax = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] c_smin = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [AW-1:0] thr(input int k);
    logic [DW-1:0] full;
    full = c_smin;
    thr  = AW'(full >> ((SEGS - k) * SHIFT));
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            upd_q, upd_d;
  logic            tick_w;
  logic [AW-1:0]   acc_q [NCH], acc_d [NCH];
  logic [AW-1:0]   lvl_q [NCH], lvl_d [NCH];
  logic [AW-1:0]   abs_w [NCH], max_w [NCH];
  logic [DW-1:0]   raw_w [NCH];
  logic [NW-1:0]   d_q [NCH], d_d [NCH];
  logic [NW-1:0]   p_q [NCH], p_d [NCH];
  logic [NW-1:0]   n_w [NCH];
  logic [HW-1:0]   hold_q [NCH], hold_d [NCH];
  logic [SEGS-1:0] seg_w [NCH];
  logic [SEGS-1:0] led_q [NCH], led_d [NCH];
  logic [NCH-1:0]  clip_q, clip_d;

  always_comb begin
    tick_w = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d  = tick_w ? '0 : cnt_q + CW'(1);
    upd_d  = tick_w;
    for (int c = 0; c < NCH; c++) begin
      raw_w[c] = bus.smp[c*DW +: DW];
      // The most negative code has no positive twin, so it saturates.
      if (raw_w[c] == c_smin)      abs_w[c] = {AW{1'b1}};
      else if (raw_w[c][DW-1])     abs_w[c] = AW'(-raw_w[c]);
      else                         abs_w[c] = raw_w[c][AW-1:0];
      max_w[c] = (bus.smp_vld && (abs_w[c] > acc_q[c])) ? abs_w[c] : acc_q[c];
      acc_d[c] = tick_w ? '0 : max_w[c];
      lvl_d[c] = tick_w ? max_w[c] : lvl_q[c];

      n_w[c] = '0;
      for (int k = 0; k < SEGS; k++) begin
        if (lvl_q[c] >= thr(k)) n_w[c] = n_w[c] + NW'(1);
      end

      d_d[c]    = d_q[c];
      p_d[c]    = p_q[c];
      hold_d[c] = hold_q[c];
      if (upd_q) begin
        d_d[c] = (n_w[c] >= d_q[c]) ? n_w[c] : d_q[c] - NW'(1);
        if (n_w[c] >= p_q[c]) begin
          p_d[c]    = n_w[c];
          hold_d[c] = HW'(HOLD_TICKS);
        end else if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - HW'(1);
        end else if (p_q[c] != '0) begin
          p_d[c] = p_q[c] - NW'(1);
        end
      end

      // Segment s is the (s+1)-th LED, so "segment d-1" is s+1 == d.
      seg_w[c] = '0;
      led_d[c] = '0;
      for (int s = 0; s < SEGS; s++) begin
        if (bus.mode) seg_w[c][s] = (NW'(s + 1) == d_q[c]) || (NW'(s + 1) == p_q[c]);
        else          seg_w[c][s] = (NW'(s) < d_q[c]) || (NW'(s + 1) == p_q[c]);
        led_d[c][MIRROR[c] ? (SEGS - 1 - s) : s] = seg_w[c][s];
      end

      clip_d[c] = (clip_q[c] && !bus.clip_clr) ||
                  (bus.smp_vld && ((raw_w[c] == c_smin) || (raw_w[c] == c_smax)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      upd_q  <= 1'b0;
      clip_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= '0;
        lvl_q[c]  <= '0;
        d_q[c]    <= '0;
        p_q[c]    <= '0;
        hold_q[c] <= '0;
        led_q[c]  <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      upd_q  <= upd_d;
      clip_q <= clip_d;
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= acc_d[c];
        lvl_q[c]  <= lvl_d[c];
        d_q[c]    <= d_d[c];
        p_q[c]    <= p_d[c];
        hold_q[c] <= hold_d[c];
        led_q[c]  <= led_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) bus.LED[c*SEGS +: SEGS] = led_q[c];
  end
  assign bus.clip = clip_q;
endmodule
`default_nettype wire

// File: tb/tb_audio_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_level_meter
// Purpose  : Directed bench with a windowed-peak meter model for the VU meter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_level_meter;
  localparam int             NCH    = 2;
  localparam int             DW     = 16;
  localparam int             SEGS   = 4;
  localparam int             TDIV   = 16;
  localparam int             HOLD   = 2;
  localparam logic [NCH-1:0] MIRROR = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  audio_level_meter_if #(.NCH(NCH), .DW(DW), .SEGS(SEGS)) bus ();

  audio_level_meter #(
    .NCH(NCH), .DW(DW), .SEGS(SEGS), .SHIFT(2),
    .TICK_DIV(TDIV), .HOLD_TICKS(HOLD), .MIRROR(MIRROR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference meter: window peak -> segment count -> bar/peak -> LED pattern.
  int         m_cnt = 0;
  bit         m_upd = 0;
  int         m_acc [NCH];
  int         m_lvl [NCH];
  int         m_d   [NCH];
  int         m_p   [NCH];
  int         m_hold[NCH];
  logic [7:0] m_led  = '0;
  logic [1:0] m_clip = '0;

  function automatic int absval(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int quant(input int lvl);
    int n;
    n = 0;
    for (int k = 0; k < SEGS; k++) if (lvl >= (32768 >> ((SEGS - k) * 2))) n++;
    return n;
  endfunction

  function automatic logic [3:0] seg_map(input int d, input int p, input bit md, input bit mir);
    logic [3:0] r;
    bit on;
    r = '0;
    for (int s = 0; s < SEGS; s++) begin
      on = md ? (s == d - 1 || s == p - 1) : (s < d || s == p - 1);
      if (mir) r[SEGS - 1 - s] = on;
      else     r[s] = on;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int a, n;
    bit tk;
    logic [15:0] raw;
    if (rst) begin
      m_cnt = 0; m_upd = 0; m_led = '0; m_clip = '0;
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_lvl[c] = 0; m_d[c] = 0; m_p[c] = 0; m_hold[c] = 0;
      end
    end else begin
      tk = (m_cnt == TDIV - 1);
      for (int c = 0; c < NCH; c++) begin
        m_led[c*4 +: 4] = seg_map(m_d[c], m_p[c], bus.mode, MIRROR[c]);
        if (m_upd) begin
          n = quant(m_lvl[c]);
          m_d[c] = (n >= m_d[c]) ? n : m_d[c] - 1;
          if (n >= m_p[c]) begin m_p[c] = n; m_hold[c] = HOLD; end
          else if (m_hold[c] != 0) m_hold[c]--;
          else if (m_p[c] != 0) m_p[c]--;
        end
        raw = bus.smp[c*DW +: DW];
        a = bus.smp_vld ? absval(raw) : 0;
        if (tk) begin
          m_lvl[c] = (a > m_acc[c]) ? a : m_acc[c];
          m_acc[c] = 0;
        end else if (a > m_acc[c]) begin
          m_acc[c] = a;
        end
        if (bus.clip_clr) m_clip[c] = 1'b0;
        if (bus.smp_vld && (raw == 16'h8000 || raw == 16'h7FFF)) m_clip[c] = 1'b1;
      end
      m_upd = tk;
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total += 2;
      if (bus.LED !== m_led) begin
        bad++;
        $display("FAIL model_led t=%0t got=%b want=%b", $time, bus.LED, m_led);
      end
      if (bus.clip !== m_clip) begin
        bad++;
        $display("FAIL model_clip t=%0t got=%b want=%b", $time, bus.clip, m_clip);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] a0, input logic [15:0] a1);
    bus.smp_vld = v;
    bus.smp     = {a1, a0};
  endtask

  task automatic align();
    int i;
    i = 0;
    while (m_cnt != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (m_cnt != 0) begin
      bad++;
      $display("FAIL align got=%0d want=0", m_cnt);
    end
  endtask

  // One full window; with last_only only the tick-edge cycle carries a sample.
  task automatic feed(input logic [15:0] a0, input logic [15:0] a1, input bit last_only);
    for (int i = 0; i < TDIV; i++) begin
      if (last_only && i < TDIV - 1) set_in(1'b0, 16'h0, 16'h0);
      else                           set_in(1'b1, a0, a1);
      @(negedge clk);
    end
    set_in(1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    set_in(1'b0, 16'h0, 16'h0);
    bus.mode     = 1'b0;
    bus.clip_clr = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      check_lit("rst_led", bus.LED, 8'h00);
      check_lit("rst_clip", {6'b0, bus.clip}, 8'h00);
    end
    rst = 1'b0;
    feed(16'h0800, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    check_lit("first_window", bus.LED, 8'b0000_1110);

    align();
    feed(16'h2000, 16'h0080, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_lit("bar_full", bus.LED, 8'b0001_1111);

    repeat (TDIV) @(negedge clk);
    check_lit("fall_tick1", bus.LED, 8'b0001_1111);
    repeat (TDIV) @(negedge clk);
    check_lit("fall_tick2", bus.LED, 8'b0001_1101);
    bus.mode = 1'b1;
    @(negedge clk);
    check_lit("dot_mode", bus.LED, 8'b0001_0101);
    repeat (TDIV - 1) @(negedge clk);
    check_lit("dot_tick3", bus.LED, 8'b0000_1010);
    bus.mode = 1'b0;
    repeat (TDIV * 3) @(negedge clk);

    set_in(1'b1, 16'h0000, 16'h8000);
    @(negedge clk);
    check_lit("clip_set", {6'b0, bus.clip}, 8'h02);
    set_in(1'b1, 16'h0000, 16'h7FFF);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    check_lit("clip_set_clr", {6'b0, bus.clip}, 8'h02);
    set_in(1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_lit("clip_clr", {6'b0, bus.clip}, 8'h00);
    bus.clip_clr = 1'b0;

    repeat (TDIV * 10) @(negedge clk);
    bus.mode = 1'b1;
    align();
    feed(16'h7FFF, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_lit("tick_edge_smp", bus.LED, 8'b0000_0001);
    repeat (TDIV) @(negedge clk);
    check_lit("acc_cleared", bus.LED, 8'b0000_0011);
    bus.mode = 1'b0;

    align();
    feed(16'h7FFF, 16'h7FFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_lit("full_both", bus.LED, 8'hFF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_lit("mid_rst_led", bus.LED, 8'h00);
    check_lit("mid_rst_clip", {6'b0, bus.clip}, 8'h00);
    rst = 1'b0;

    align();
    feed(16'hFE00, 16'h0200, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_lit("neg_sym", bus.LED, 8'b0011_1100);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
